// File: rtl/mux151_scan_ctl_pkg.sv
// Shared types and sizes for the 74S151 scan controller.
package mux151_pkg;

  localparam int MUX_SEL_W = 3;
  localparam int MUX_N_IN  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } scan_state_e;

endpackage

// File: rtl/mux151_scan_ctl_if.sv
// Bundle between the scan controller, its requester and the 74S151 pins.
// slave is the controller side; master is the requester plus the mux outputs.
interface mux151_scan_ctl_if
  import mux151_pkg::*;
  ();

  logic                 start;
  logic                 busy;
  logic                 done;
  logic [MUX_N_IN-1:0]  data;
  logic                 err;
  logic [MUX_SEL_W-1:0] sel;
  logic                 ce_n;
  logic                 q;
  logic                 q_n;

  modport master (
    output start,
    output q,
    output q_n,
    input  busy,
    input  done,
    input  data,
    input  err,
    input  sel,
    input  ce_n
  );

  modport slave (
    input  start,
    input  q,
    input  q_n,
    output busy,
    output done,
    output data,
    output err,
    output sel,
    output ce_n
  );

endinterface

// File: rtl/mux151_scan_ctl_settle_timer.sv
// Down-counter that holds each mux input for SETTLE_CYCLES cycles before
// the controller samples Q. expired is high while the count sits at zero.
module mux151_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("mux151_settle_timer: SETTLE_CYCLES must be at least 1");
  end

  logic [CNT_W-1:0] cnt;

  // Reload on entry to a settle window, otherwise count down to zero and stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/mux151_scan_ctl.sv
// Scan sequencer for one 74S151: steps SEL 0..7, waits SETTLE_CYCLES per
// input, samples Q into a shadow byte and publishes it atomically on done.
// Optional feature: define MUX151_SCAN_CHECK_EN to compare Q against Q_N on
// every sample and raise a sticky err flag when they agree.
module mux151_scan_ctl
  import mux151_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  mux151_scan_ctl_if.slave bus
);

  localparam logic [MUX_SEL_W-1:0] LAST_SEL = MUX_SEL_W'(MUX_N_IN - 1);

  scan_state_e          state, state_nxt;
  logic [MUX_SEL_W-1:0] sel_r, sel_nxt;
  logic [MUX_N_IN-1:0]  shadow, shadow_nxt;
  logic [MUX_N_IN-1:0]  data_r, data_nxt;
  logic                 tmr_load;
  logic                 tmr_expired;

`ifdef MUX151_SCAN_CHECK_EN
  logic err_r, err_nxt;
`else
  logic unused_qn;
  assign unused_qn = bus.q_n;
`endif

  mux151_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .count   (state == SETTLE),
    .expired (tmr_expired)
  );

  // State, select counter, shadow byte and published result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sel_r  <= '0;
      shadow <= '0;
      data_r <= '0;
`ifdef MUX151_SCAN_CHECK_EN
      err_r  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      sel_r  <= sel_nxt;
      shadow <= shadow_nxt;
      data_r <= data_nxt;
`ifdef MUX151_SCAN_CHECK_EN
      err_r  <= err_nxt;
`endif
    end
  end

  // Next-state logic; the result byte is loaded together with the last
  // sample so that it is already valid during the done cycle.
  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel_r;
    shadow_nxt = shadow;
    data_nxt   = data_r;
    tmr_load   = 1'b0;
`ifdef MUX151_SCAN_CHECK_EN
    err_nxt    = err_r;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt  = SETTLE;
          sel_nxt    = '0;
          shadow_nxt = '0;
          tmr_load   = 1'b1;
`ifdef MUX151_SCAN_CHECK_EN
          err_nxt    = 1'b0;
`endif
        end
      end
      SETTLE: begin
        if (tmr_expired) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        shadow_nxt[sel_r] = bus.q;
`ifdef MUX151_SCAN_CHECK_EN
        if (bus.q == bus.q_n) begin
          err_nxt = 1'b1;
        end
`endif
        if (sel_r == LAST_SEL) begin
          state_nxt = DONE;
          sel_nxt   = '0;
          data_nxt  = shadow_nxt;
        end else begin
          state_nxt = SETTLE;
          sel_nxt   = sel_r + MUX_SEL_W'(1);
          tmr_load  = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.ce_n = !((state == SETTLE) || (state == SAMPLE));
  assign bus.sel  = sel_r;
  assign bus.data = data_r;
`ifdef MUX151_SCAN_CHECK_EN
  assign bus.err  = err_r;
`else
  assign bus.err  = 1'b0;
`endif

endmodule
